// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp decode and default timing for the
// N-way traffic-light controller and its helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  // Lamp triple {red, yellow, green} shown on the active approach
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int DEF_N_WAYS    = 4;
  localparam int DEF_GREEN_MIN = 4;
  localparam int DEF_GREEN_MAX = 12;
  localparam int DEF_YELLOW_T  = 2;
  localparam int DEF_ALLRED_T  = 1;

  function automatic logic [2:0] lamp_of(state_t s);
    logic [2:0] l;
    unique case (s)
      ST_GREEN:  l = LAMP_G;
      ST_YELLOW: l = LAMP_Y;
      default:   l = LAMP_R;
    endcase
    return l;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after
// start, wrapping modulo N_WAYS.
module rr_pick #(
  parameter int N_WAYS = 4,
  parameter int IW     = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] req,
  input  logic [IW-1:0]     start,
  output logic [IW-1:0]     idx,
  output logic              found
);

  // Walk from the far end so the nearest match is written last
  always_comb begin
    idx   = start;
    found = 1'b0;
    for (int k = N_WAYS - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N_WAYS]) begin
        found = 1'b1;
        idx   = IW'((int'(start) + k) % N_WAYS);
      end
    end
  end

endmodule

// File: rtl/traffic_light_nway.sv
// N-approach traffic-light controller: round-robin service with
// bounded green time, fixed yellow/all-red clearance and preemption.
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter int N_WAYS    = DEF_N_WAYS,
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_WAYS-1:0]         sense,
  input  logic                      preempt,
  input  logic [$clog2(N_WAYS)-1:0] preempt_idx,
  output logic [N_WAYS-1:0]         red,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         green,
  output logic [$clog2(N_WAYS)-1:0] active
);

  localparam int IW = $clog2(N_WAYS);
  localparam int TW =
    $clog2(max3(GREEN_MAX, YELLOW_T, ALLRED_T) + 1);

  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [TW-1:0] T_MIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] T_MAX = TW'(GREEN_MAX);
  localparam logic [TW-1:0] T_Y   = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_AR  = TW'(ALLRED_T);
  localparam logic [IW-1:0] LAST  = IW'(N_WAYS - 1);

  if (N_WAYS < 2 || N_WAYS > 16) begin : g_bad_n
    $error("traffic_light_nway: N_WAYS must be 2..16");
  end
  if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_g
    $error("traffic_light_nway: need 1 <= GREEN_MIN <= GREEN_MAX");
  end
  if (YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_c
    $error("traffic_light_nway: YELLOW_T and ALLRED_T must be >= 1");
  end

  state_t            r_state;
  state_t            w_nstate;
  logic [IW-1:0]     r_cur;
  logic [IW-1:0]     w_ncur;
  logic [IW-1:0]     w_start;
  logic [IW-1:0]     w_pick;
  logic              w_found;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_ntimer;
  logic [N_WAYS-1:0] w_cur_oh;
  logic [N_WAYS-1:0] w_ncur_oh;
  logic [N_WAYS-1:0] r_red;
  logic [N_WAYS-1:0] r_yel;
  logic [N_WAYS-1:0] r_grn;
  logic [2:0]        w_lamp;
  logic              w_pv;
  logic              w_hold;
  logic              w_other;
  logic              w_leave;

  // Out-of-range preemption targets are treated as no request
  assign w_pv     = preempt &&
                    ({1'b0, preempt_idx} < (IW+1)'(N_WAYS));
  assign w_hold   = w_pv && (preempt_idx == r_cur);
  assign w_cur_oh = N_WAYS'(1) << r_cur;
  assign w_other  = |(sense & ~w_cur_oh);
  assign w_start  = (r_cur == LAST) ? '0 : r_cur + 1'b1;

  assign w_leave =
    (w_pv && !w_hold) ||
    (!w_hold && w_other &&
     ((r_timer >= T_MIN && !sense[r_cur]) ||
      r_timer >= T_MAX));

  rr_pick #(
    .N_WAYS (N_WAYS),
    .IW     (IW)
  ) u_pick (
    .req   (sense),
    .start (w_start),
    .idx   (w_pick),
    .found (w_found)
  );

  always_comb begin
    w_nstate = r_state;
    w_ncur   = r_cur;
    w_ntimer = r_timer + 1'b1;
    unique case (r_state)
      ST_ALLRED: begin
        if (r_timer >= T_AR) begin
          w_nstate = ST_GREEN;
          w_ntimer = T_ONE;
          if (w_pv)         w_ncur = preempt_idx;
          else if (w_found) w_ncur = w_pick;
        end
      end
      ST_GREEN: begin
        if (w_leave) begin
          w_nstate = ST_YELLOW;
          w_ntimer = T_ONE;
        end else if (r_timer >= T_MAX) begin
          w_ntimer = r_timer;
        end
      end
      ST_YELLOW: begin
        if (r_timer >= T_Y) begin
          w_nstate = ST_ALLRED;
          w_ntimer = T_ONE;
        end
      end
      default: begin
        w_nstate = ST_ALLRED;
        w_ntimer = T_ONE;
      end
    endcase
  end

  assign w_lamp    = lamp_of(w_nstate);
  assign w_ncur_oh = N_WAYS'(1) << w_ncur;

  // Lamps are registered alongside the state they decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ALLRED;
      r_cur   <= LAST;
      r_timer <= T_ONE;
      r_red   <= '1;
      r_yel   <= '0;
      r_grn   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cur   <= w_ncur;
      r_timer <= w_ntimer;
      r_red   <= w_lamp[2] ? '1 : ~w_ncur_oh;
      r_yel   <= w_lamp[1] ? w_ncur_oh : '0;
      r_grn   <= w_lamp[0] ? w_ncur_oh : '0;
    end
  end

  assign red    = r_red;
  assign yellow = r_yel;
  assign green  = r_grn;
  assign active = r_cur;

endmodule

// File: tb/tb_traffic_light_nway.sv
// Scoreboard bench for traffic_light_nway at default parameters:
// a cycle model queues expected lamps, plus directed scenario checks.
module tb_traffic_light_nway;

  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YT   = 2;
  localparam int ART  = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [1:0] a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sense = '0;
  logic       preempt = 1'b0;
  logic [1:0] preempt_idx = '0;
  logic [3:0] red;
  logic [3:0] yellow;
  logic [3:0] green;
  logic [1:0] active;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_st;
  int   m_cur;
  int   m_t;

  traffic_light_nway dut (
    .clk         (clk),
    .rst         (rst),
    .sense       (sense),
    .preempt     (preempt),
    .preempt_idx (preempt_idx),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] s,
                            input logic p,
                            input logic [1:0] pi);
    bit others;
    bit hold;
    others = (s & ~(4'b0001 << m_cur)) != 4'b0000;
    hold   = p && (int'(pi) == m_cur);
    case (m_st)
      0: begin
        if (m_t == ART) begin
          m_st = 1;
          m_t  = 1;
          if (p) begin
            m_cur = int'(pi);
          end else begin
            for (int k = 1; k <= 4; k++) begin
              if (s[(m_cur + k) % 4]) begin
                m_cur = (m_cur + k) % 4;
                break;
              end
            end
          end
        end else m_t++;
      end
      1: begin
        if (p && !hold) begin
          m_st = 2; m_t = 1;
        end else if (!hold && others &&
                     (m_t >= GMAX || (m_t >= GMIN && !s[m_cur]))) begin
          m_st = 2; m_t = 1;
        end else if (m_t < GMAX) m_t++;
      end
      default: begin
        if (m_t == YT) begin
          m_st = 0; m_t = 1;
        end else m_t++;
      end
    endcase
  endtask

  task automatic sb_cmp();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_red", red, e.r);
      check("sb_yellow", yellow, e.y);
      check("sb_green", green, e.g);
      check("sb_active", active, e.a);
    end
    check("one_lamp_each",
          ((red | yellow | green) == 4'hF) &&
          (((red & yellow) | (red & green) | (yellow & green)) == 4'h0),
          1);
    check("one_nonred", $countones(~red) <= 1, 1);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input logic [3:0] s,
                      input logic p,
                      input logic [1:0] pi);
    exp_t e;
    sb_cmp();
    sense       = s;
    preempt     = p;
    preempt_idx = pi;
    model_step(s, p, pi);
    e.r = 4'hF;
    e.y = 4'h0;
    e.g = 4'h0;
    e.a = 2'(m_cur);
    if (m_st == 1) begin
      e.g[m_cur] = 1'b1;
      e.r[m_cur] = 1'b0;
    end else if (m_st == 2) begin
      e.y[m_cur] = 1'b1;
      e.r[m_cur] = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    sense       = '0;
    preempt     = 1'b0;
    preempt_idx = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_red", red, 4'hF);
    check("rst_yellow", yellow, 4'h0);
    check("rst_green", green, 4'h0);
    check("rst_active", active, 3);
    rst   = 1'b0;
    m_st  = 0;
    m_cur = 3;
    m_t   = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   ng;
    int   gr[2];
    bit   saw2;
    logic [3:0] pg;

    // Idle after reset: grant stays on approach 3
    do_reset();
    step(4'b0000, 1'b0, 2'd0);
    check("idle_green", green, 4'b1000);
    check("idle_active", active, 3);
    repeat (50) step(4'b0000, 1'b0, 2'd0);
    check("idle_hold", green, 4'b1000);

    // Minimum green then hand-off to a new request
    do_reset();
    step(4'b0001, 1'b0, 2'd0);
    check("s2_green0", green, 4'b0001);
    repeat (6) step(4'b0001, 1'b0, 2'd0);
    step(4'b0100, 1'b0, 2'd0);
    check("s2_yel1", yellow, 4'b0001);
    step(4'b0100, 1'b0, 2'd0);
    check("s2_yel2", yellow, 4'b0001);
    step(4'b0100, 1'b0, 2'd0);
    check("s2_allred", red, 4'hF);
    step(4'b0100, 1'b0, 2'd0);
    check("s2_green2", green, 4'b0100);
    check("s2_active", active, 2);

    // Maximum green when current approach stays busy
    do_reset();
    step(4'b0001, 1'b0, 2'd0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (green[0]) cnt++;
      else break;
      step(4'b0011, 1'b0, 2'd0);
    end
    check("gmax_len", cnt, GMAX);
    check("gmax_yel", yellow, 4'b0001);

    // Round-robin order from approach 1 with 3 and 0 waiting
    do_reset();
    step(4'b0010, 1'b0, 2'd0);
    check("rr_start", green, 4'b0010);
    pg    = green;
    ng    = 0;
    gr[0] = -1;
    gr[1] = -1;
    saw2  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step(4'b1001, 1'b0, 2'd0);
      if (green != 4'b0 && green != pg && ng < 2) begin
        gr[ng] = int'(active);
        ng++;
      end
      if (green[2] || yellow[2]) saw2 = 1'b1;
      pg = green;
    end
    check("rr_grants", ng, 2);
    check("rr_first", gr[0], 3);
    check("rr_second", gr[1], 0);
    check("rr_skip2", saw2, 0);

    // Preemption at green timer 1 toward approach 1
    do_reset();
    step(4'b0000, 1'b0, 2'd0);
    check("pre_green3", green, 4'b1000);
    step(4'b0100, 1'b1, 2'd1);
    check("pre_yel", yellow, 4'b1000);
    repeat (2) step(4'b0100, 1'b1, 2'd1);
    check("pre_allred", red, 4'hF);
    step(4'b0100, 1'b1, 2'd1);
    check("pre_green1", green, 4'b0010);
    repeat (20) step(4'b0100, 1'b1, 2'd1);
    check("pre_hold", green, 4'b0010);

    // Asynchronous reset during yellow
    do_reset();
    step(4'b0000, 1'b0, 2'd0);
    step(4'b0000, 1'b1, 2'd0);
    check("ar_yel", yellow, 4'b1000);
    #1 rst = 1'b1;
    #1;
    check("ar_red", red, 4'hF);
    check("ar_yellow", yellow, 4'h0);
    check("ar_green", green, 4'h0);
    check("ar_active", active, 3);
    do_reset();
    step(4'b0000, 1'b0, 2'd0);
    check("ar_regrant", green, 4'b1000);
    check("ar_reactive", active, 3);
    repeat (3) step(4'b0000, 1'b0, 2'd0);

    sb_cmp();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
